// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-register scoreboard.
// Reads are registered, bypass a same-cycle write, and flag reads of locked registers.
module regfile_sb #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 4,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic [SEL_W-1:0]    rd_sel_0,
    input  logic                rd_en_0,
    input  logic [SEL_W-1:0]    rd_sel_1,
    input  logic                rd_en_1,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [SEL_W-1:0]    lock_sel,
    input  logic                lock_en,
    output logic [DATA_W-1:0]   rd_data_0,
    output logic [DATA_W-1:0]   rd_data_1,
    output logic                rd_busy_0,
    output logic                rd_busy_1,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [1:0][DATA_W-1:0]          rd_data_q, rd_data_d;
    logic [1:0]                      rd_busy_q, rd_busy_d;
    logic [1:0][SEL_W-1:0]           rd_sel;
    logic [1:0]                      rd_en;

    assign rd_sel = {rd_sel_1, rd_sel_0};
    assign rd_en  = {rd_en_1, rd_en_0};

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[wr_sel] = wr_data;
            busy_d[wr_sel] = 1'b0;
        end
        // Applied after the clear so a new lock on the written register wins.
        if (lock_en)
            busy_d[lock_sel] = 1'b1;
    end

    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
                if (wr_en && (wr_sel == rd_sel[p]))
                    rd_data_d[p] = wr_data;
                else
                    rd_data_d[p] = regs_q[rd_sel[p]];
                // Pre-edge scoreboard: a same-cycle lock does not flag this read.
                rd_busy_d[p] = busy_q[rd_sel[p]] && !(wr_en && (wr_sel == rd_sel[p]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            regs_q    <= '0;
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data_0 = rd_data_q[0];
    assign rd_data_1 = rd_data_q[1];
    assign rd_busy_0 = rd_busy_q[0];
    assign rd_busy_1 = rd_busy_q[1];
    assign busy_vec  = busy_q;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 8: register and data width in bits; legal range 1..64.
REQ-002 Parameter NUM_REGS, default 4: register count; power of two, 2..64.
REQ-003 Localparam SEL_W = clog2(NUM_REGS): select width; not overridable.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_  input  1  reset; synchronous and active-low.
REQ-006 rd_sel_0  input  SEL_W  read port 0 register select.
REQ-007 rd_en_0  input  1  read port 0 enable.
REQ-008 rd_sel_1  input  SEL_W  read port 1 register select.
REQ-009 rd_en_1  input  1  read port 1 enable.
REQ-010 wr_sel  input  SEL_W  write register select.
REQ-011 wr_en  input  1  write enable.
REQ-012 wr_data  input  DATA_W  write data.
REQ-013 lock_sel  input  SEL_W  scoreboard lock select: register that an in-flight instruction will write.
REQ-014 lock_en  input  1  scoreboard lock enable.
REQ-015 rd_data_0  output  DATA_W  registered read data, port 0.
REQ-016 rd_data_1  output  DATA_W  registered read data, port 1.
REQ-017 rd_busy_0  output  1  registered hazard flag: port 0 read a locked, not-yet-written register.
REQ-018 rd_busy_1  output  1  registered hazard flag, port 1.
REQ-019 busy_vec  output  NUM_REGS  current scoreboard; bit i = register i locked.

Function
REQ-020 Write: wr_en=1 at an edge SHALL load regs[wr_sel] <= wr_data; regs SHALL be otherwise unchanged.
REQ-021 Read latency: rd_data_x SHALL be registered, valid exactly 1 cycle after rd_en_x is sampled.
REQ-022 Read next value: rd_en_x & wr_en & (rd_sel_x==wr_sel) -> wr_data (bypass); else rd_en_x -> regs[rd_sel_x]; else 0.
REQ-023 Both ports SHALL be independent; same register on both ports SHALL return identical data.
REQ-024 Scoreboard set: lock_en=1 SHALL set busy_vec[lock_sel] at the edge.
REQ-025 Scoreboard clear: wr_en=1 SHALL clear busy_vec[wr_sel] at the edge.
REQ-026 Simultaneous lock_en and wr_en, same register: data SHALL be written AND the bit SHALL end set (lock wins; new pending writer).
REQ-027 Simultaneous lock_en and wr_en, different registers: both actions SHALL apply.
REQ-028 Lock on an already-set bit SHALL leave it set; write to an unlocked register SHALL leave its bit clear (no error).
REQ-029 rd_busy_x next = rd_en_x & busy_vec[rd_sel_x] & !(wr_en & wr_sel==rd_sel_x); the busy value used is the pre-edge value, so a lock in the same cycle does not flag the read.
REQ-030 rd_busy_x SHALL be 0 whenever rd_en_x was 0; rd_data_x SHALL still follow REQ-022 when rd_busy_x=1.
REQ-031 busy_vec SHALL be a direct register output (no combinational path from inputs).

Reset
REQ-032 reset_=0 at an edge SHALL clear all regs, busy_vec, rd_data_0/1 and rd_busy_0/1 to 0, overriding concurrent wr_en, lock_en, rd_en.
REQ-033 Reset applied mid-sequence SHALL discard pending locks; the first edge with reset_=1 behaves as from power-up.

Verification (DATA_W=8, NUM_REGS=4 unless stated)
REQ-034 Reset, then rd_en_0=1 on r0..r3 -> rd_data_0=0x00 each, one cycle later; busy_vec=0000.
REQ-035 Write r2=0xA5 while rd_en_0=1, rd_sel_0=2 same cycle -> rd_data_0=0xA5 next cycle (bypass); following cycle read still 0xA5.
REQ-036 lock r1; next cycle rd_en_1=1 sel 1 -> rd_busy_1=1, busy_vec=0010; then wr r1=0x3C with read sel 1 -> rd_busy_1=0, rd_data_1=0x3C, busy_vec=0000.
REQ-037 lock r3 and wr r3=0x77 same cycle -> r3=0x77, busy_vec=1000; lock r0 and wr r3 same cycle -> busy_vec=0001.
REQ-038 r0..r3 written nonzero and r2 locked, then reset_=0 one cycle with wr_en=1 -> all regs, outputs, busy_vec = 0.
REQ-039 DATA_W=16, NUM_REGS=16: write r15=0xBEEF, lock r8, read r15/r8 on ports 0/1 -> 0xBEEF/0x0000, rd_busy_1=1.
